// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the raster timing generator.
//   mode_t      : pattern select (grid, colour bars, checkerboard, external)
//   rgb_t       : 24-bit packed {r, g, b} pixel
//   RGB_*       : colour constants used by the bar pattern
//   bar_colour(): bar index (0 = leftmost) -> colour
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_GRID    = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_EXT     = 2'd3
    } mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
    localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
    localparam rgb_t RGB_CYAN    = 24'h00FFFF;
    localparam rgb_t RGB_GREEN   = 24'h00FF00;
    localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
    localparam rgb_t RGB_RED     = 24'hFF0000;
    localparam rgb_t RGB_BLUE    = 24'h0000FF;
    localparam rgb_t RGB_BLACK   = 24'h000000;

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_if.sv
// -----------------------------------------------------------------------------
// video_if
// Parallel LCD/VGA output bundle.
//   CLK   : pixel clock forwarded to the panel
//   HS/VS : sync pulses (polarity set by the driving generator)
//   BLANK : 1 = visible pixel, 0 = blanked
//   RGB   : 24-bit {R,G,B}
// -----------------------------------------------------------------------------
interface video_if;
    logic        CLK;
    logic        HS;
    logic        VS;
    logic        BLANK;
    logic [23:0] RGB;

    modport master (output CLK, HS, VS, BLANK, RGB);
    modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_pattern_rom.sv
// -----------------------------------------------------------------------------
// vga_pattern_rom
// Combinational test-pattern source for the internal modes.
//   mode   in  pattern select (MODE_EXT yields black; the top handles it)
//   h_cnt  in  horizontal counter
//   v_low  in  low GRID_LOG2+1 bits of the vertical counter
//   rgb    out pattern colour for (h_cnt, v_cnt)
// Only the low vertical bits are needed: grid and checker look at bits
// [GRID_LOG2:0] and the bars are purely horizontal.
// -----------------------------------------------------------------------------
module vga_pattern_rom
    import vga_pkg::*;
#(
    parameter int HDISP     = 800,
    parameter int GRID_LOG2 = 4,
    parameter int H_W       = 10
) (
    input  mode_t              mode,
    input  logic [H_W-1:0]     h_cnt,
    input  logic [GRID_LOG2:0] v_low,
    output rgb_t               rgb
);

    localparam int BAR_W = HDISP / 8;

    logic [2:0] bar_idx;

    // Threshold chain rather than a divider; anything past the 8th
    // threshold (the integer-division remainder) stays in the last bar.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(h_cnt) >= i * BAR_W) bar_idx = 3'(i);
        end
    end

    always_comb begin
        rgb = RGB_BLACK;
        case (mode)
            MODE_GRID: begin
                if ((h_cnt[GRID_LOG2-1:0] == '0) || (v_low[GRID_LOG2-1:0] == '0))
                    rgb = RGB_WHITE;
            end
            MODE_BARS:    rgb = bar_colour(bar_idx);
            MODE_CHECKER: begin
                if (h_cnt[GRID_LOG2] ^ v_low[GRID_LOG2]) rgb = RGB_WHITE;
            end
            default:      rgb = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator and pattern source.
//   pixel_clk      in   pixel clock
//   pixel_rst      in   synchronous active-high reset
//   mode           in   0 grid, 1 bars, 2 checker, 3 external stream
//   pix_data       in   external pixel {R,G,B}
//   pix_valid      in   pix_data valid
//   pix_ready      out  pix_data consumed this cycle (external mode, active)
//   sof            out  pulse on the first active pixel of a frame
//   underflow      out  sticky: ready seen without valid
//   underflow_clr  in   clears underflow (a same-cycle underflow wins)
//   underflow_cnt  out  [VGA_UNDERFLOW_CNT_EN only] saturating underflow count
//   video_ifm      video_if.master: CLK, HS, VS, BLANK, RGB
// Optional feature macro: VGA_UNDERFLOW_CNT_EN.
// All video outputs are registered one cycle after the counters they decode.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   HDISP     = 800,
    parameter int   VDISP     = 480,
    parameter int   HFP       = 40,
    parameter int   HPULSE    = 48,
    parameter int   HBP       = 40,
    parameter int   VFP       = 13,
    parameter int   VPULSE    = 3,
    parameter int   VBP       = 29,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   GRID_LOG2 = 4
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic [1:0]  mode,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        sof,
    output logic        underflow,
    input  logic        underflow_clr,
`ifdef VGA_UNDERFLOW_CNT_EN
    output logic [15:0] underflow_cnt,
`endif
    video_if.master     video_ifm
);

    localparam int H_TOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int V_TOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(HDISP);
    localparam logic [H_W-1:0] HS_START = H_W'(HDISP + HFP);
    localparam logic [H_W-1:0] HS_END   = H_W'(HDISP + HFP + HPULSE);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT    = V_W'(VDISP);
    localparam logic [V_W-1:0] VS_START = V_W'(VDISP + VFP);
    localparam logic [V_W-1:0] VS_END   = V_W'(VDISP + VFP + VPULSE);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    mode_t          mode_lat;

    logic  at_origin_p0;
    logic  act_p0;
    logic  hs_act_p0;
    logic  vs_act_p0;
    logic  uf_evt_p0;
    mode_t mode_eff_p0;
    rgb_t  rom_rgb_p0;
    rgb_t  rgb_nxt_p0;

    logic  hs_p1;
    logic  vs_p1;
    logic  blank_p1;
    rgb_t  rgb_p1;

    // ---- Stage 0: counters and decode ----
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            mode_lat <= MODE_GRID;
        end else begin
            if (at_origin_p0) mode_lat <= mode_t'(mode);
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
            end else begin
                h_cnt <= h_cnt + H_W'(1);
            end
        end
    end

    assign at_origin_p0 = (h_cnt == '0) && (v_cnt == '0);
    // The origin pixel already belongs to the new frame, so it uses the
    // freshly sampled mode; every later pixel uses the latched copy.
    assign mode_eff_p0  = at_origin_p0 ? mode_t'(mode) : mode_lat;
    assign act_p0       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_act_p0    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_act_p0    = (v_cnt >= VS_START) && (v_cnt < VS_END);

    assign pix_ready = act_p0 && (mode_eff_p0 == MODE_EXT);
    assign sof       = act_p0 && at_origin_p0;
    assign uf_evt_p0 = pix_ready && !pix_valid;

    vga_pattern_rom #(
        .HDISP     (HDISP),
        .GRID_LOG2 (GRID_LOG2),
        .H_W       (H_W)
    ) u_rom (
        .mode  (mode_eff_p0),
        .h_cnt (h_cnt),
        .v_low (v_cnt[GRID_LOG2:0]),
        .rgb   (rom_rgb_p0)
    );

    always_comb begin
        rgb_nxt_p0 = RGB_BLACK;
        if (act_p0) begin
            if (mode_eff_p0 == MODE_EXT)
                rgb_nxt_p0 = pix_valid ? rgb_t'(pix_data) : RGB_BLACK;
            else
                rgb_nxt_p0 = rom_rgb_p0;
        end
    end

    // ---- Stage 1: registered video outputs and underflow status ----
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            hs_p1    <= ~HS_POL;
            vs_p1    <= ~VS_POL;
            blank_p1 <= 1'b0;
            rgb_p1   <= RGB_BLACK;
        end else begin
            hs_p1    <= hs_act_p0 ? HS_POL : ~HS_POL;
            vs_p1    <= vs_act_p0 ? VS_POL : ~VS_POL;
            blank_p1 <= act_p0;
            rgb_p1   <= rgb_nxt_p0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst)          underflow <= 1'b0;
        else if (uf_evt_p0)     underflow <= 1'b1;
        else if (underflow_clr) underflow <= 1'b0;
    end

`ifdef VGA_UNDERFLOW_CNT_EN
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst)
            underflow_cnt <= '0;
        else if (underflow_clr)
            underflow_cnt <= uf_evt_p0 ? 16'd1 : 16'd0;
        else if (uf_evt_p0 && (underflow_cnt != 16'hFFFF))
            underflow_cnt <= underflow_cnt + 16'd1;
    end
`endif

    assign video_ifm.CLK   = pixel_clk;
    assign video_ifm.HS    = hs_p1;
    assign video_ifm.VS    = vs_p1;
    assign video_ifm.BLANK = blank_p1;
    assign video_ifm.RGB   = rgb_p1;

endmodule
